// File: rtl/tone_pkg.sv
// Shared definitions for the tone-generator chain (phase accumulator and sine stage).
package tone_pkg;

  // Output phase width and sine output width, common with the sine stage.
  localparam int PSZ = 12;
  localparam int OSZ = 16;

  // Default portamento shift: the increment closes 1/2^GSH of the gap per tick.
  localparam int GSH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_GLIDE = 2'd2
  } state_t;

endpackage

// File: rtl/glide_step.sv
// One portamento step: moves the increment a fraction of the way toward the target,
// snapping onto the target once the remaining step rounds to 0 or -1.
module glide_step #(
  parameter int fsz = 20,
  parameter int gsh = 4
) (
  input  logic [fsz-1:0] i_inc,
  input  logic [fsz-1:0] i_tgt,
  output logic [fsz-1:0] o_next_inc,
  output logic           o_done
);

  logic signed [fsz:0] w_d;
  logic signed [fsz:0] w_s;

  // Signed gap and its arithmetic-shifted (floor) step.
  always_comb begin
    w_d        = $signed({1'b0, i_tgt}) - $signed({1'b0, i_inc});
    w_s        = w_d >>> gsh;
    o_done     = (w_s == '0) || (w_s == '1);
    o_next_inc = o_done ? i_tgt : i_inc + w_s[fsz-1:0];
  end

endmodule

// File: rtl/phase_acc.sv
// NCO phase accumulator: takes frequency words over valid/ready, applies them on
// sample ticks (optionally gliding), and presents the top psz bits of the phase.
module phase_acc
  import tone_pkg::*;
#(
  parameter int asz = 24,
  parameter int psz = PSZ,
  parameter int fsz = 20,
  parameter int gsh = GSH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ena,
  input  logic           gate,
  input  logic           gl,
  input  logic           fw_valid,
  output logic           fw_ready,
  input  logic [fsz-1:0] fw,
  input  logic           fw_sync,
  output logic [psz-1:0] phs,
  output logic           phs_vld
);

  logic [asz-1:0] r_acc;
  logic [fsz-1:0] r_inc;
  logic [fsz-1:0] r_tgt;
  logic           r_syn;
  logic           r_pend;
  state_t         r_state;
  logic           r_tick;
  logic [psz-1:0] r_phs;
  logic           r_phs_vld;

  logic [asz-1:0] w_acc_nxt;
  logic [fsz-1:0] w_inc_nxt;
  logic [fsz-1:0] w_tgt_nxt;
  logic           w_syn_nxt;
  logic           w_pend_nxt;
  state_t         w_state_nxt;
  logic           w_accept;
  logic           w_apply;
  logic [fsz-1:0] w_step_inc;
  logic           w_step_done;

  assign w_accept = fw_valid && !r_pend;
  assign w_apply  = ena && r_pend;
  assign fw_ready = !r_pend;
  assign phs      = r_phs;
  assign phs_vld  = r_phs_vld;

  glide_step #(
    .fsz(fsz),
    .gsh(gsh)
  ) u_glide (
    .i_inc     (r_inc),
    .i_tgt     (r_tgt),
    .o_next_inc(w_step_inc),
    .o_done    (w_step_done)
  );

  // Next-state, handshake and accumulator update.
  always_comb begin
    w_acc_nxt   = r_acc;
    w_inc_nxt   = r_inc;
    w_tgt_nxt   = r_tgt;
    w_syn_nxt   = r_syn;
    w_pend_nxt  = r_pend;
    w_state_nxt = r_state;

    if (w_accept) begin
      w_tgt_nxt  = fw;
      w_syn_nxt  = fw_sync;
      w_pend_nxt = 1'b1;
    end
    if (w_apply) w_pend_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_acc_nxt = '0;
        if (w_apply) w_inc_nxt = r_tgt;
        if (gate) w_state_nxt = S_RUN;
      end
      S_RUN, S_GLIDE: begin
        if (!gate) begin
          // Gate drop wins over glide: any word applied now lands directly.
          w_acc_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (w_apply) w_inc_nxt = r_tgt;
        end else if (ena) begin
          w_acc_nxt = (w_apply && r_syn) ? '0 : r_acc + asz'(r_inc);
          if (r_state == S_GLIDE) begin
            // A glide-enabled word applied mid-glide simply keeps stepping toward the new tgt.
            if (w_apply && !gl) begin
              w_inc_nxt   = r_tgt;
              w_state_nxt = S_RUN;
            end else begin
              w_inc_nxt = w_step_inc;
              if (w_step_done) w_state_nxt = S_RUN;
            end
          end else if (w_apply) begin
            if (gl) w_state_nxt = S_GLIDE;
            else    w_inc_nxt   = r_tgt;
          end
        end
      end
      default: begin
        w_acc_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Oscillator state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_inc   <= '0;
      r_tgt   <= '0;
      r_syn   <= 1'b0;
      r_pend  <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      r_acc   <= w_acc_nxt;
      r_inc   <= w_inc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_syn   <= w_syn_nxt;
      r_pend  <= w_pend_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Output stage: phase and strobe one cycle after each tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick    <= 1'b0;
      r_phs     <= '0;
      r_phs_vld <= 1'b0;
    end else begin
      r_tick    <= ena;
      r_phs_vld <= r_tick;
      if (r_tick) r_phs <= r_acc[asz-1 -: psz];
    end
  end

endmodule

// File: tb/tb_phase_acc.sv
// Self-checking bench for phase_acc: directed vectors, corner sequences and random traffic
// against a behavioural oscillator model.
module tb_phase_acc;
  import tone_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ena = 1'b0;
  logic        gate = 1'b0;
  logic        gl = 1'b0;
  logic        fw_valid = 1'b0;
  logic        fw_ready;
  logic [19:0] fw = '0;
  logic        fw_sync = 1'b0;
  logic [11:0] phs;
  logic        phs_vld;

  int n_checks = 0;
  int n_fail   = 0;

  phase_acc #(.asz(24), .psz(12), .fsz(20), .gsh(4)) dut (
    .clk(clk), .reset(reset), .ena(ena), .gate(gate), .gl(gl),
    .fw_valid(fw_valid), .fw_ready(fw_ready), .fw(fw), .fw_sync(fw_sync),
    .phs(phs), .phs_vld(phs_vld)
  );

  always #5 clk = ~clk;

  // Behavioural model: oscillator on/off, glide flag, arithmetic on plain integers.
  longint m_acc = 0, m_inc = 0, m_tgt = 0;
  bit     m_syn = 0, m_pend = 0, m_on = 0, m_gliding = 0;
  bit     m_tick = 0, m_vld = 0;
  int     m_phs = 0;

  task automatic model_step();
    bit apply, accept;
    longint d, q;
    if (reset) begin
      m_acc = 0; m_inc = 0; m_tgt = 0; m_syn = 0; m_pend = 0;
      m_on = 0; m_gliding = 0; m_tick = 0; m_vld = 0; m_phs = 0;
      return;
    end
    apply  = ena && m_pend;
    accept = fw_valid && !m_pend;
    m_vld = m_tick;
    if (m_tick) m_phs = int'(m_acc >> 12);
    m_tick = ena;
    if (!m_on) begin
      if (apply) m_inc = m_tgt;
      m_acc = 0;
      if (gate) begin m_on = 1; m_gliding = 0; end
    end else if (!gate) begin
      if (apply) m_inc = m_tgt;
      m_acc = 0; m_on = 0; m_gliding = 0;
    end else if (ena) begin
      m_acc = (apply && m_syn) ? 0 : (m_acc + m_inc) % (longint'(1) << 24);
      if (m_gliding) begin
        if (apply && !gl) begin
          m_inc = m_tgt; m_gliding = 0;
        end else begin
          d = m_tgt - m_inc;
          q = (d >= 0) ? d / 16 : -((-d + 15) / 16);
          if (q == 0 || q == -1) begin m_inc = m_tgt; m_gliding = 0; end
          else m_inc = m_inc + q;
        end
      end else if (apply) begin
        if (gl) m_gliding = 1;
        else    m_inc = m_tgt;
      end
    end
    if (apply) m_pend = 0;
    if (accept) begin m_tgt = fw; m_syn = fw_sync; m_pend = 1; end
  endtask

  // Model advances with the DUT clock and follows the asynchronous reset.
  always @(posedge clk or posedge reset) model_step();

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: outputs compared with the model on the falling edge, inputs then change after the rise.
  task automatic cyc();
    @(negedge clk);
    check("phs", longint'(phs), longint'(m_phs));
    check("phs_vld", longint'(phs_vld), longint'(m_vld));
    check("fw_ready", longint'(fw_ready), m_pend ? 0 : 1);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    ena = 1'b1; cyc(); ena = 1'b0;
  endtask

  task automatic tick_flush();
    tick(); cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  task automatic send_word(input logic [19:0] w, input logic s);
    int unsigned k = 0;
    while (!fw_ready && k < 200) begin cyc(); k++; end
    check("send_ready", longint'(fw_ready), 1);
    fw_valid = 1'b1; fw = w; fw_sync = s;
    cyc();
    fw_valid = 1'b0; fw_sync = 1'b0;
  endtask

  // Run at 0x08000 for a while, then start gliding toward 0x18000.
  task automatic setup_glide();
    do_reset();
    gate = 1'b1; gl = 1'b0; cyc();
    send_word(20'h08000, 1'b0);
    repeat (20) tick();
    gl = 1'b1;
    send_word(20'h18000, 1'b0);
    repeat (3) tick();
    cyc();
  endtask

  typedef struct {
    logic [19:0] fw;
    int          n;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [19:0] words[2];
    int          n_acc;
    int          k2;
    bit          acc_now;

    vecs[0] = '{fw: 20'h10000, n: 1,   exp: 12'h000};
    vecs[1] = '{fw: 20'h10000, n: 128, exp: 12'h7F0};
    vecs[2] = '{fw: 20'h10000, n: 129, exp: 12'h800};
    vecs[3] = '{fw: 20'h10000, n: 257, exp: 12'h000};
    vecs[4] = '{fw: 20'h00100, n: 17,  exp: 12'h001};
    vecs[5] = '{fw: 20'hFFFFF, n: 3,   exp: 12'h1FF};
    vecs[6] = '{fw: 20'h12345, n: 5,   exp: 12'h048};

    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_phs", longint'(phs), 0);
    check("rst_vld", longint'(phs_vld), 0);
    check("rst_ready", longint'(fw_ready), 1);
    check("rst_state", longint'(dut.r_state), longint'(S_IDLE));
    cyc();
    reset = 1'b0;

    // Table: first tick applies the word, the remaining n-1 ticks advance by fw.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      gate = 1'b1; gl = 1'b0; cyc();
      send_word(vecs[i].fw, 1'b0);
      ena = 1'b1;
      repeat (vecs[i].n) cyc();
      ena = 1'b0;
      cyc(); cyc();
      check($sformatf("vec%0d_phs", i), longint'(phs), longint'(vecs[i].exp));
    end

    // Phase sync on apply.
    do_reset();
    gate = 1'b1; gl = 1'b0; cyc();
    send_word(20'h10000, 1'b0);
    repeat (10) tick();
    send_word(20'h20000, 1'b1);
    tick_flush();
    check("sync_zero", longint'(phs), 0);
    tick_flush();
    check("sync_step1", longint'(phs), 32);
    tick_flush();
    check("sync_step2", longint'(phs), 64);

    // Glide up then down, ending exactly on target.
    do_reset();
    gate = 1'b1; gl = 1'b0; cyc();
    send_word(20'h01000, 1'b0);
    tick();
    gl = 1'b1;
    send_word(20'h11000, 1'b0);
    tick();
    check("glide_start", longint'(dut.r_inc), 'h01000);
    tick();
    check("glide_inc1", longint'(dut.r_inc), 'h02000);
    tick();
    check("glide_inc2", longint'(dut.r_inc), 'h02F00);
    begin
      int unsigned k = 0;
      while (dut.r_inc != 20'h11000 && k < 400) begin tick(); k++; end
    end
    check("glide_up_end", longint'(dut.r_inc), 'h11000);
    check("glide_up_state", longint'(dut.r_state), longint'(S_RUN));
    send_word(20'h01000, 1'b0);
    tick();
    tick();
    check("glide_dn_inc1", longint'(dut.r_inc), 'h10000);
    begin
      int unsigned k = 0;
      while (dut.r_inc != 20'h01000 && k < 400) begin tick(); k++; end
    end
    check("glide_dn_end", longint'(dut.r_inc), 'h01000);
    check("glide_dn_state", longint'(dut.r_state), longint'(S_RUN));

    // Backpressure: two words held on valid, a tick every fourth cycle.
    do_reset();
    gate = 1'b1; gl = 1'b0; cyc();
    n_acc = 0; k2 = -1;
    fw_valid = 1'b1; fw = 20'h03000;
    for (int k = 0; k < 40; k++) begin
      ena = (k % 4 == 3);
      acc_now = fw_valid && fw_ready;
      cyc();
      if (acc_now) begin
        words[n_acc] = fw;
        n_acc++;
        if (n_acc == 1) fw = 20'h05000;
        else begin fw_valid = 1'b0; k2 = k; end
      end
    end
    ena = 1'b0;
    check("bp_count", n_acc, 2);
    check("bp_word0", longint'(words[0]), 'h03000);
    check("bp_word1", longint'(words[1]), 'h05000);
    check("bp_second_cycle", k2, 4);
    check("bp_inc", longint'(dut.r_inc), 'h05000);
    check("bp_ready", longint'(fw_ready), 1);

    // Gate drop mid-glide with a word pending.
    setup_glide();
    check("gd_pre_state", longint'(dut.r_state), longint'(S_GLIDE));
    send_word(20'h00400, 1'b0);
    gate = 1'b0;
    cyc();
    check("gd_acc", longint'(dut.r_acc), 0);
    check("gd_state", longint'(dut.r_state), longint'(S_IDLE));
    check("gd_pending", longint'(fw_ready), 0);
    tick(); cyc();
    check("gd_vld", longint'(phs_vld), 1);
    check("gd_phs", longint'(phs), 0);

    // Asynchronous reset mid-glide with a word pending.
    gate = 1'b1;
    setup_glide();
    send_word(20'h00400, 1'b0);
    check("rg_pre_ready", longint'(fw_ready), 0);
    #2 reset = 1'b1;
    #1;
    check("rg_phs", longint'(phs), 0);
    check("rg_vld", longint'(phs_vld), 0);
    check("rg_ready", longint'(fw_ready), 1);
    check("rg_state", longint'(dut.r_state), longint'(S_IDLE));
    check("rg_inc", longint'(dut.r_inc), 0);
    cyc();
    reset = 1'b0;

    // Random traffic against the model.
    gate = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      ena      = ($urandom % 3) == 0;
      if ($urandom % 64 == 0) gate = ~gate;
      else if (!gate && ($urandom % 8 == 0)) gate = 1'b1;
      gl       = $urandom % 2;
      fw_valid = ($urandom % 4) == 0;
      fw       = 20'($urandom);
      fw_sync  = ($urandom % 8) == 0;
      reset    = ($urandom % 700) == 0;
      cyc();
    end
    reset = 1'b0; ena = 1'b0; fw_valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
